// File: rtl/common_lru_way_allocator_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : common_lru_way_allocator_pkg
//  Description : Shared FSM state encoding and way-count derivation for the
//                LRU way allocator and its pseudo-LRU tree.
//  Revision    : 1.0 - initial release
// ============================================================================
package common_lru_way_allocator_pkg;

    // Allocator FSM states
    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } alloc_state_e;

    // Number of ways from its log2
    function automatic int way_count(input int way_count_log2);
        return 1 << way_count_log2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/common_lru_plru_tree.sv
`default_nettype none
// ============================================================================
//  Module      : common_lru_plru_tree
//  Description : Tree pseudo-LRU state of W-1 node bits. A node bit of 0
//                points the victim at its lower-index child. A touch moves
//                every node on the touched way's path to point away from it.
//  Revision    : 1.0 - initial release
// ============================================================================
module common_lru_plru_tree
    import common_lru_way_allocator_pkg::*;
#(
    parameter int WAY_COUNT_LOG2 = 2,
    localparam int c_WAY_COUNT = way_count(WAY_COUNT_LOG2)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   touch_en,
    input  logic [c_WAY_COUNT-1:0] touch_way,
    output logic [c_WAY_COUNT-1:0] victim
);

    // Heap layout: node n has children 2n+1 (left) and 2n+2 (right)
    logic [c_WAY_COUNT-2:0] r_node;
    logic [c_WAY_COUNT-2:0] w_node_en;
    logic [c_WAY_COUNT-2:0] w_node_val;

    // Per-node update enable (touched subtree) and new value (left half touched)
    for (genvar l = 0; l < WAY_COUNT_LOG2; l++) begin : g_level
        for (genvar k = 0; k < (1 << l); k++) begin : g_node
            localparam int c_SPAN = c_WAY_COUNT >> l;
            localparam int c_BASE = k * c_SPAN;
            localparam int c_IDX  = (1 << l) - 1 + k;
            assign w_node_en[c_IDX]  = touch_en & (|touch_way[c_BASE +: c_SPAN]);
            assign w_node_val[c_IDX] = |touch_way[c_BASE +: (c_SPAN / 2)];
        end
    end

    // Node flops: clear wins over touch
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_node <= '0;
        end else if (clear) begin
            r_node <= '0;
        end else begin
            r_node <= (r_node & ~w_node_en) | (w_node_val & w_node_en);
        end
    end

    // A way is the victim when every node on its path points toward it
    for (genvar w = 0; w < c_WAY_COUNT; w++) begin : g_way
        logic [WAY_COUNT_LOG2-1:0] w_match;
        for (genvar l = 0; l < WAY_COUNT_LOG2; l++) begin : g_path
            localparam int c_IDX = (1 << l) - 1 + (w >> (WAY_COUNT_LOG2 - l));
            localparam bit c_DIR = ((w >> (WAY_COUNT_LOG2 - 1 - l)) & 1) != 0;
            assign w_match[l] = (r_node[c_IDX] == c_DIR);
        end
        assign victim[w] = &w_match;
    end

endmodule
`default_nettype wire

// File: rtl/common_lru_way_allocator.sv
`default_nettype none
// ============================================================================
//  Module      : common_lru_way_allocator
//  Description : Victim-way allocator for a single fully-associative set.
//                Prefers the lowest invalid way, falls back to the PLRU
//                victim, and holds the grant until fill done or abort.
//  Revision    : 1.0 - initial release
// ============================================================================
module common_lru_way_allocator
    import common_lru_way_allocator_pkg::*;
#(
    parameter int WAY_COUNT_LOG2 = 2,
    localparam int c_WAY_COUNT = way_count(WAY_COUNT_LOG2)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   touch_en,
    input  logic [c_WAY_COUNT-1:0] touch_way,
    input  logic                   alloc_req,
    output logic                   alloc_gnt,
    output logic [c_WAY_COUNT-1:0] alloc_way,
    input  logic                   fill_done,
    input  logic                   fill_abort,
    input  logic                   inv_en,
    input  logic [c_WAY_COUNT-1:0] inv_way,
    input  logic                   flush,
    output logic [c_WAY_COUNT-1:0] valid_q,
    output logic                   busy
);

    alloc_state_e           r_state;
    alloc_state_e           w_state_next;
    logic [c_WAY_COUNT-1:0] r_valid;
    logic [c_WAY_COUNT-1:0] r_victim;
    logic [c_WAY_COUNT-1:0] w_valid_next;
    logic [c_WAY_COUNT-1:0] w_victim_next;
    logic [c_WAY_COUNT-1:0] w_first_invalid;
    logic [c_WAY_COUNT-1:0] w_tree_victim;
    logic [c_WAY_COUNT-1:0] w_select;
    logic [c_WAY_COUNT-1:0] w_tree_touch_way;
    logic                   w_tree_touch_en;
    logic                   w_start;
    logic                   w_done;
    logic                   w_abort;
    logic                   w_touch_ok;

    common_lru_plru_tree #(
        .WAY_COUNT_LOG2 (WAY_COUNT_LOG2)
    ) u_tree (
        .clk       (clk),
        .reset     (reset),
        .clear     (flush),
        .touch_en  (w_tree_touch_en),
        .touch_way (w_tree_touch_way),
        .victim    (w_tree_victim)
    );

    // Lowest invalid way (isolate lowest zero bit), else the PLRU victim
    always_comb begin
        w_first_invalid = ~r_valid & (r_valid + c_WAY_COUNT'(1));
        w_select        = (&r_valid) ? w_tree_victim : w_first_invalid;
    end

    // Next-state, valid/victim update and tree-touch arbitration
    always_comb begin
        w_state_next     = r_state;
        w_valid_next     = r_valid;
        w_victim_next    = r_victim;
        w_start          = (r_state == IDLE) && alloc_req;
        w_done           = (r_state == GRANT) && fill_done;
        w_abort          = (r_state == GRANT) && fill_abort && !fill_done;
        // Touches of invalid ways (including the in-flight victim) are dropped
        w_touch_ok       = touch_en && (|(touch_way & r_valid));
        // A completing fill owns the tree port for that cycle
        w_tree_touch_en  = w_done || w_touch_ok;
        w_tree_touch_way = w_done ? r_victim : touch_way;

        case (r_state)
            IDLE:    if (w_start) w_state_next = GRANT;
            GRANT:   if (w_done || w_abort) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase

        if (w_start) begin
            w_victim_next = w_select;
            w_valid_next  = w_valid_next & ~w_select;
        end
        if (w_done) begin
            w_valid_next = w_valid_next | r_victim;
        end
        // Invalidate applied last so it beats a same-cycle fill
        if (inv_en) begin
            w_valid_next = w_valid_next & ~inv_way;
        end

        if (flush) begin
            w_state_next  = IDLE;
            w_valid_next  = '0;
            w_victim_next = '0;
        end
    end

    // State, valid and victim registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_valid  <= '0;
            r_victim <= '0;
        end else begin
            r_state  <= w_state_next;
            r_valid  <= w_valid_next;
            r_victim <= w_victim_next;
        end
    end

    assign alloc_gnt = (r_state == GRANT);
    assign busy      = (r_state == GRANT);
    assign alloc_way = (r_state == GRANT) ? r_victim : '0;
    assign valid_q   = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_common_lru_way_allocator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_common_lru_way_allocator
//  Description : Self-checking bench for common_lru_way_allocator (W=4):
//                directed vector table, async reset mid-grant, and random
//                traffic against a behavioural reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_common_lru_way_allocator;

    localparam int L = 2;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         touch_en;
    logic [W-1:0] touch_way;
    logic         alloc_req;
    logic         alloc_gnt;
    logic [W-1:0] alloc_way;
    logic         fill_done;
    logic         fill_abort;
    logic         inv_en;
    logic [W-1:0] inv_way;
    logic         flush;
    logic [W-1:0] valid_q;
    logic         busy;

    int n_cmp = 0;
    int n_bad = 0;

    common_lru_way_allocator #(.WAY_COUNT_LOG2(L)) dut (
        .clk        (clk),
        .reset      (reset),
        .touch_en   (touch_en),
        .touch_way  (touch_way),
        .alloc_req  (alloc_req),
        .alloc_gnt  (alloc_gnt),
        .alloc_way  (alloc_way),
        .fill_done  (fill_done),
        .fill_abort (fill_abort),
        .inv_en     (inv_en),
        .inv_way    (inv_way),
        .flush      (flush),
        .valid_q    (valid_q),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    bit m_valid [W];
    bit m_tree  [W-1];
    bit m_gnt;
    int m_vic;

    function automatic void m_reset();
        for (int i = 0; i < W; i++) m_valid[i] = 1'b0;
        for (int i = 0; i < W - 1; i++) m_tree[i] = 1'b0;
        m_gnt = 1'b0;
        m_vic = 0;
    endfunction

    function automatic int onehot_idx(input logic [W-1:0] v);
        for (int i = 0; i < W; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Walk root to leaf: each bit on the way picks the child the victim sits in
    function automatic int m_tree_victim();
        int n = 0;
        int way = 0;
        for (int l = 0; l < L; l++) begin
            int b = m_tree[n] ? 1 : 0;
            way = way * 2 + b;
            n = 2 * n + 1 + b;
        end
        return way;
    endfunction

    function automatic void m_touch(input int way);
        int n = 0;
        for (int l = 0; l < L; l++) begin
            int b = (way >> (L - 1 - l)) & 1;
            m_tree[n] = (b == 0);
            n = 2 * n + 1 + b;
        end
    endfunction

    function automatic logic [W-1:0] m_valid_vec();
        logic [W-1:0] v;
        for (int i = 0; i < W; i++) v[i] = m_valid[i];
        return v;
    endfunction

    function automatic logic [W-1:0] m_way_vec();
        logic [W-1:0] v = '0;
        if (m_gnt) v[m_vic] = 1'b1;
        return v;
    endfunction

    function automatic void model_step();
        bit ov [W];
        int tw;
        int iw;
        int v;
        ov = m_valid;
        tw = onehot_idx(touch_way);
        iw = onehot_idx(inv_way);
        if (flush) begin
            m_reset();
            return;
        end
        if (!m_gnt) begin
            if (alloc_req) begin
                v = -1;
                for (int i = W - 1; i >= 0; i--) if (!ov[i]) v = i;
                if (v < 0) v = m_tree_victim();
                m_valid[v] = 1'b0;
                m_gnt = 1'b1;
                m_vic = v;
            end
            if (touch_en && tw >= 0 && ov[tw]) m_touch(tw);
        end else begin
            if (fill_done) begin
                m_valid[m_vic] = 1'b1;
                m_touch(m_vic);
                m_gnt = 1'b0;
            end else begin
                if (touch_en && tw >= 0 && ov[tw]) m_touch(tw);
                if (fill_abort) m_gnt = 1'b0;
            end
        end
        if (inv_en && iw >= 0) m_valid[iw] = 1'b0;
    endfunction

    // ---------------- checking ----------------
    function automatic void check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endfunction

    task automatic idle_inputs();
        touch_en = 0; touch_way = '0; alloc_req = 0; fill_done = 0;
        fill_abort = 0; inv_en = 0; inv_way = '0; flush = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("model.gnt",   {3'b0, alloc_gnt}, {3'b0, m_gnt});
        check("model.busy",  {3'b0, busy},      {3'b0, m_gnt});
        check("model.way",   alloc_way,         m_way_vec());
        check("model.valid", valid_q,           m_valid_vec());
    endtask

    // ---------------- directed vector table ----------------
    typedef struct packed {
        logic [W-1:0] tw;   // touch way, 0 = no touch
        logic         ar;
        logic         fd;
        logic         fa;
        logic [W-1:0] iw;   // invalidate way, 0 = no invalidate
        logic         fl;
        logic         eg;
        logic [W-1:0] ew;
        logic [W-1:0] ev;
    } vec_t;

    localparam int NV = 33;
    vec_t tbl [NV];

    function automatic vec_t mk(input logic [W-1:0] tw, input logic ar, input logic fd,
                                input logic fa, input logic [W-1:0] iw, input logic fl,
                                input logic eg, input logic [W-1:0] ew, input logic [W-1:0] ev);
        vec_t r;
        r.tw = tw; r.ar = ar; r.fd = fd; r.fa = fa; r.iw = iw; r.fl = fl;
        r.eg = eg; r.ew = ew; r.ev = ev;
        return r;
    endfunction

    initial begin
        //            tw       ar fd fa iw      fl   eg ew       ev
        tbl[0]  = mk(4'b0000, 1, 0, 0, 4'b0000, 0,   1, 4'b0001, 4'b0000);
        tbl[1]  = mk(4'b0000, 0, 1, 0, 4'b0000, 0,   0, 4'b0000, 4'b0001);
        tbl[2]  = mk(4'b0000, 1, 0, 0, 4'b0000, 0,   1, 4'b0010, 4'b0001);
        tbl[3]  = mk(4'b0000, 0, 1, 0, 4'b0000, 0,   0, 4'b0000, 4'b0011);
        tbl[4]  = mk(4'b0000, 1, 0, 0, 4'b0000, 0,   1, 4'b0100, 4'b0011);
        tbl[5]  = mk(4'b0000, 0, 1, 0, 4'b0000, 0,   0, 4'b0000, 4'b0111);
        tbl[6]  = mk(4'b0000, 1, 0, 0, 4'b0000, 0,   1, 4'b1000, 4'b0111);
        tbl[7]  = mk(4'b0000, 0, 1, 0, 4'b0000, 0,   0, 4'b0000, 4'b1111);
        tbl[8]  = mk(4'b0001, 0, 0, 0, 4'b0000, 0,   0, 4'b0000, 4'b1111);
        tbl[9]  = mk(4'b0100, 0, 0, 0, 4'b0000, 0,   0, 4'b0000, 4'b1111);
        tbl[10] = mk(4'b0000, 1, 0, 0, 4'b0000, 0,   1, 4'b0010, 4'b1101);
        tbl[11] = mk(4'b0000, 0, 0, 1, 4'b0000, 0,   0, 4'b0000, 4'b1101);
        tbl[12] = mk(4'b0000, 1, 0, 0, 4'b0000, 0,   1, 4'b0010, 4'b1101);
        tbl[13] = mk(4'b0000, 0, 1, 0, 4'b0000, 0,   0, 4'b0000, 4'b1111);
        tbl[14] = mk(4'b0000, 0, 0, 0, 4'b0100, 0,   0, 4'b0000, 4'b1011);
        tbl[15] = mk(4'b0000, 1, 0, 0, 4'b0000, 0,   1, 4'b0100, 4'b1011);
        tbl[16] = mk(4'b0100, 1, 0, 0, 4'b0000, 0,   1, 4'b0100, 4'b1011);
        tbl[17] = mk(4'b0000, 0, 1, 0, 4'b0000, 0,   0, 4'b0000, 4'b1111);
        tbl[18] = mk(4'b0000, 1, 0, 0, 4'b0000, 0,   1, 4'b0001, 4'b1110);
        tbl[19] = mk(4'b0000, 0, 1, 0, 4'b0000, 1,   0, 4'b0000, 4'b0000);
        tbl[20] = mk(4'b0000, 1, 0, 0, 4'b0000, 0,   1, 4'b0001, 4'b0000);
        tbl[21] = mk(4'b0000, 0, 1, 0, 4'b0000, 0,   0, 4'b0000, 4'b0001);
        tbl[22] = mk(4'b0000, 1, 0, 0, 4'b0000, 0,   1, 4'b0010, 4'b0001);
        tbl[23] = mk(4'b0000, 0, 1, 0, 4'b0010, 0,   0, 4'b0000, 4'b0001);
        tbl[24] = mk(4'b0000, 1, 0, 0, 4'b0000, 0,   1, 4'b0010, 4'b0001);
        tbl[25] = mk(4'b0000, 0, 1, 1, 4'b0000, 0,   0, 4'b0000, 4'b0011);
        tbl[26] = mk(4'b0000, 1, 0, 0, 4'b0000, 0,   1, 4'b0100, 4'b0011);
        tbl[27] = mk(4'b0001, 0, 1, 0, 4'b0000, 0,   0, 4'b0000, 4'b0111);
        tbl[28] = mk(4'b0000, 1, 0, 0, 4'b0000, 0,   1, 4'b1000, 4'b0111);
        tbl[29] = mk(4'b0000, 0, 1, 0, 4'b0000, 0,   0, 4'b0000, 4'b1111);
        tbl[30] = mk(4'b0000, 1, 0, 0, 4'b0000, 0,   1, 4'b0001, 4'b1110);
        tbl[31] = mk(4'b0000, 0, 1, 0, 4'b0000, 0,   0, 4'b0000, 4'b1111);
        tbl[32] = mk(4'b0000, 0, 1, 0, 4'b0000, 0,   0, 4'b0000, 4'b1111);
    end

    // ---------------- test sequence ----------------
    initial begin
        reset = 1'b0;
        idle_inputs();
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset.gnt",   {3'b0, alloc_gnt}, 4'b0000);
        check("reset.busy",  {3'b0, busy},      4'b0000);
        check("reset.way",   alloc_way,         4'b0000);
        check("reset.valid", valid_q,           4'b0000);
        reset = 1'b1;

        // Directed table
        for (int i = 0; i < NV; i++) begin
            idle_inputs();
            touch_en   = |tbl[i].tw;
            touch_way  = tbl[i].tw;
            alloc_req  = tbl[i].ar;
            fill_done  = tbl[i].fd;
            fill_abort = tbl[i].fa;
            inv_en     = |tbl[i].iw;
            inv_way    = tbl[i].iw;
            flush      = tbl[i].fl;
            tick();
            check($sformatf("tbl[%0d].gnt", i),   {3'b0, alloc_gnt}, {3'b0, tbl[i].eg});
            check($sformatf("tbl[%0d].way", i),   alloc_way,         tbl[i].ew);
            check($sformatf("tbl[%0d].valid", i), valid_q,           tbl[i].ev);
        end

        // Asynchronous reset in the middle of a grant, between clock edges
        idle_inputs();
        alloc_req = 1'b1;
        tick();
        check("pre_reset.gnt", {3'b0, alloc_gnt}, 4'b0001);
        idle_inputs();
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("async_reset.gnt",   {3'b0, alloc_gnt}, 4'b0000);
        check("async_reset.busy",  {3'b0, busy},      4'b0000);
        check("async_reset.way",   alloc_way,         4'b0000);
        check("async_reset.valid", valid_q,           4'b0000);
        m_reset();
        #1;
        reset = 1'b1;
        alloc_req = 1'b1;
        tick();
        check("post_reset.way", alloc_way, 4'b0001);

        // Randomized traffic against the reference model
        for (int c = 0; c < 3000; c++) begin
            idle_inputs();
            touch_en   = ($urandom_range(0, 1) == 1);
            touch_way  = 4'b0001 << $urandom_range(0, 3);
            alloc_req  = ($urandom_range(0, 2) != 0);
            fill_done  = ($urandom_range(0, 3) == 0);
            fill_abort = ($urandom_range(0, 5) == 0);
            inv_en     = ($urandom_range(0, 5) == 0);
            inv_way    = 4'b0001 << $urandom_range(0, 3);
            flush      = ($urandom_range(0, 59) == 0);
            tick();
        end

        idle_inputs();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
